// File: rtl/seg7_display_ctrl.sv
// Binary to seven-segment display controller: sequential double-dabble
// decimal conversion or direct hex mapping, with blanking and overflow dashes.
module seg7_display_ctrl #(
    parameter int IN_WIDTH = 12,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   value,
    input  logic                  mode,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex_out
);

    // One spare nibble of headroom above the displayed digits.
    localparam int BCD_W = 4*DIGITS + 4;
    localparam int NIBS  = BCD_W / 4;
    localparam int PAD_W = (IN_WIDTH > 4*DIGITS) ? IN_WIDTH : 4*DIGITS;
    localparam int CMP_W = (IN_WIDTH > 32) ? IN_WIDTH : 32;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    localparam logic [CMP_W-1:0] DEC_MAX  = CMP_W'(10**DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH);
    localparam logic [6:0]       BLANK    = 7'b1111111;
    localparam logic [6:0]       DASH     = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_e;

    state_e                state_q, state_d;
    logic [IN_WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic                  blz_q, blz_d;
    logic                  ovf_lat_q, ovf_lat_d;
    logic [7*DIGITS-1:0]   hex_q, hex_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  dec_ovf, hex_ovf;
    logic [BCD_W-1:0]      adj;
    logic [PAD_W-1:0]      binx;
    logic [7*DIGITS-1:0]   enc;

    function automatic logic [6:0] glyph(input logic [3:0] n, input logic hx);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        if (!hx && n > 4'd9) g = BLANK;
        return g;
    endfunction

    assign dec_ovf = CMP_W'(value) > DEC_MAX;
    assign hex_ovf = |(PAD_W'(value) >> (4*DIGITS));
    assign binx    = PAD_W'(bin_q);

    always_comb begin
        adj = '0;
        for (int i = 0; i < NIBS; i++) begin
            logic [3:0] nib;
            nib = 4'(bcd_q >> (4*i));
            adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
    end

    // Scan from the most significant digit so blanking stops at the first non-zero.
    always_comb begin
        logic       seen;
        logic [3:0] nib;
        logic [6:0] g;
        enc  = '1;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = mode_q ? 4'(binx >> (4*i)) : 4'(bcd_q >> (4*i));
            if (nib != 4'd0) seen = 1'b1;
            g = glyph(nib, mode_q);
            if (ovf_lat_q)
                g = DASH;
            else if (blz_q && !seen && i != 0)
                g = BLANK;
            enc[7*i +: 7] = g;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            blz_q     <= 1'b0;
            ovf_lat_q <= 1'b0;
            hex_q     <= '1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            blz_q     <= blz_d;
            ovf_lat_q <= ovf_lat_d;
            hex_q     <= hex_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = mode ? ENCODE : SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(1)) state_d = ENCODE;
            ENCODE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        blz_d     = blz_q;
        ovf_lat_d = ovf_lat_q;
        hex_d     = hex_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d     = value;
                    bcd_d     = '0;
                    cnt_d     = CNT_LOAD;
                    mode_d    = mode;
                    blz_d     = blank_lz;
                    ovf_lat_d = mode ? hex_ovf : dec_ovf;
                end
            end
            SHIFT: begin
                bcd_d = BCD_W'({adj, bin_q[IN_WIDTH-1]});
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
            end
            ENCODE: begin
                hex_d  = enc;
                ovf_d  = ovf_lat_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign hex_out  = hex_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Randomised self-checking bench for seg7_display_ctrl against an
// arithmetic display model.
module tb_seg7_display_ctrl;

    localparam int W = 12;
    localparam int D = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   value;
    logic           mode;
    logic           blank_lz;
    logic           busy;
    logic           done;
    logic           overflow;
    logic [7*D-1:0] hex_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_display_ctrl #(.IN_WIDTH(W), .DIGITS(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .mode     (mode),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .hex_out  (hex_out)
    );

    function automatic logic [6:0] gl(input int n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic void model(input int v, input bit m, input bit b,
                                  output logic [7*D-1:0] h, output bit ov);
        int dg [D];
        int p;
        int msd;
        ov = m ? ((v >> (4*D)) != 0) : (v > 10**D - 1);
        p  = 1;
        for (int i = 0; i < D; i++) begin
            dg[i] = m ? ((v >> (4*i)) & 15) : ((v / p) % 10);
            p = p * 10;
        end
        msd = 0;
        for (int i = 0; i < D; i++)
            if (dg[i] != 0) msd = i;
        for (int i = 0; i < D; i++) begin
            if (ov)
                h[7*i +: 7] = 7'b0111111;
            else if (b && i > msd)
                h[7*i +: 7] = 7'b1111111;
            else
                h[7*i +: 7] = gl(dg[i]);
        end
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion; lat = edges from accept to the done edge, -1 on timeout.
    task automatic convert(input int v, input bit m, input bit b,
                           output int lat, output int busy_bad);
        start    = 1'b1;
        value    = W'(v);
        mode     = m;
        blank_lz = b;
        step;
        start    = 1'b0;
        lat      = -1;
        busy_bad = 0;
        if (!busy) busy_bad++;
        for (int n = 1; n <= 100; n++) begin
            step;
            if (done) begin
                lat = n;
                if (busy) busy_bad++;
                break;
            end else if (!busy) begin
                busy_bad++;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; value = '0; mode = 1'b0; blank_lz = 1'b0;
        step; step;
        checks++;
        if (hex_out !== '1) begin
            errors++; $display("FAIL reset_hex got %h want %h", hex_out, {7*D{1'b1}});
        end
        checks++;
        if ({busy, done, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {busy, done, overflow});
        end
        reset = 1'b0;
        step;
    endtask

    task automatic test_decimal;
        int lat, bb;
        convert(255, 1'b0, 1'b0, lat, bb);
        checks++;
        if (lat != 13) begin errors++; $display("FAIL dec_latency got %0d want 13", lat); end
        checks++;
        if (bb != 0) begin errors++; $display("FAIL dec_busy got %0d bad cycles want 0", bb); end
        checks++;
        if (hex_out !== {7'b0100100, 7'b0010010, 7'b0010010} || overflow !== 1'b0) begin
            errors++; $display("FAIL dec_255 got %b ov %b want 255 ov 0", hex_out, overflow);
        end
        step;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL dec_done_pulse got %b want 0", done); end
    endtask

    task automatic test_hex;
        int lat, bb;
        convert('hABC, 1'b1, 1'b0, lat, bb);
        checks++;
        if (lat != 1 || bb != 0) begin
            errors++; $display("FAIL hex_latency got %0d bad %0d want 1 bad 0", lat, bb);
        end
        checks++;
        if (hex_out !== {7'b0001000, 7'b0000011, 7'b1000110}) begin
            errors++; $display("FAIL hex_abc got %b want AbC", hex_out);
        end
        step;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL hex_done_pulse got %b want 0", done); end
    endtask

    task automatic test_blanking;
        int lat, bb;
        convert(7, 1'b0, 1'b1, lat, bb);
        checks++;
        if (hex_out !== {7'b1111111, 7'b1111111, 7'b1111000}) begin
            errors++; $display("FAIL blank_7 got %b want __7", hex_out);
        end
        step;
        convert(0, 1'b0, 1'b1, lat, bb);
        checks++;
        if (hex_out !== {7'b1111111, 7'b1111111, 7'b1000000}) begin
            errors++; $display("FAIL blank_0 got %b want __0", hex_out);
        end
        step;
    endtask

    task automatic test_overflow;
        int lat, bb;
        convert(1000, 1'b0, 1'b1, lat, bb);
        checks++;
        if (hex_out !== {3{7'b0111111}} || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_1000 got %b ov %b want dashes ov 1", hex_out, overflow);
        end
        step;
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b want 1", overflow); end
        convert(999, 1'b0, 1'b0, lat, bb);
        checks++;
        if (hex_out !== {3{7'b0010000}} || overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_999 got %b ov %b want 999 ov 0", hex_out, overflow);
        end
        step;
    endtask

    task automatic test_start_busy;
        int dones;
        start = 1'b1; value = W'(123); mode = 1'b0; blank_lz = 1'b0;
        step;
        start = 1'b0;
        step; step; step;
        start = 1'b1; value = W'(456);
        step;
        start = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (done) dones++;
            step;
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL busy_done_count got %0d want 1", dones); end
        checks++;
        if (hex_out !== {7'b1111001, 7'b0100100, 7'b0110000} || busy !== 1'b0) begin
            errors++; $display("FAIL busy_ignore got %b busy %b want 123 busy 0", hex_out, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7*D-1:0] h;
        bit ov;
        int dones, lat, bb;
        start = 1'b1; value = W'('h123); mode = 1'b1; blank_lz = 1'b0;
        step;
        value = W'('h456);
        step;
        start = 1'b0;
        model('h123, 1'b1, 1'b0, h, ov);
        checks++;
        if (done !== 1'b1 || hex_out !== h) begin
            errors++; $display("FAIL b2b_first got done %b %b want 1 %b", done, hex_out, h);
        end
        dones = 0;
        for (int n = 0; n < 5; n++) begin
            step;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL b2b_encode_start got %0d want 0", dones); end
        convert('h7E, 1'b1, 1'b1, lat, bb);
        convert(88, 1'b0, 1'b1, lat, bb);
        model(88, 1'b0, 1'b1, h, ov);
        checks++;
        if (lat != W + 1 || hex_out !== h) begin
            errors++; $display("FAIL b2b_next got lat %0d %b want %0d %b", lat, hex_out, W + 1, h);
        end
        step;
    endtask

    task automatic test_reset_mid;
        logic [7*D-1:0] h;
        bit ov;
        int dones, lat, bb;
        start = 1'b1; value = W'(321); mode = 1'b0; blank_lz = 1'b0;
        step;
        start = 1'b0;
        step; step; step; step; step;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (hex_out !== '1 || busy !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %b busy %b done %b ov %b want blank 000",
                               hex_out, busy, done, overflow);
        end
        step;
        reset = 1'b0;
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            step;
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL mid_reset_done got %0d want 0", dones); end
        convert(321, 1'b0, 1'b1, lat, bb);
        model(321, 1'b0, 1'b1, h, ov);
        checks++;
        if (hex_out !== h || lat != W + 1) begin
            errors++; $display("FAIL mid_reset_after got %b lat %0d want %b", hex_out, lat, h);
        end
        step;
    endtask

    task automatic test_random;
        logic [7*D-1:0] h;
        bit ov, m, b;
        int v, lat, bb, want;
        for (int k = 0; k < 60; k++) begin
            v = int'($urandom_range(0, (1 << W) - 1));
            if (k % 4 == 0) v = int'($urandom_range(0, 20));
            m = 1'($urandom);
            b = 1'($urandom);
            model(v, m, b, h, ov);
            want = m ? 1 : W + 1;
            convert(v, m, b, lat, bb);
            checks++;
            if (lat != want || bb != 0) begin
                errors++; $display("FAIL rnd_timing v=%0d m=%0d got lat %0d bad %0d want %0d",
                                   v, m, lat, bb, want);
            end
            checks++;
            if (hex_out !== h || overflow !== ov) begin
                errors++; $display("FAIL rnd_disp v=%0d m=%0d b=%0d got %b ov %b want %b ov %b",
                                   v, m, b, hex_out, overflow, h, ov);
            end
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step;
        end
    endtask

    initial begin
        test_reset;
        test_decimal;
        test_hex;
        test_blanking;
        test_overflow;
        test_start_busy;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
- Parametrised successor to the fixed 3-digit BCD-to-seven-segment decoder.
- Accepts a binary word on a start strobe and converts it sequentially to decimal with a shift-add-3 (double-dabble) engine, or maps it directly to hexadecimal.
- Drives DIGITS active-low seven-segment displays from registered outputs, with leading-zero blanking and overflow indication.
- Sits between the AES datapath/status logic and the board HEX displays.

Parameters:
- IN_WIDTH, 12, width of the binary input value (≥4).
- DIGITS, 3, number of seven-segment digits driven (1..8).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of value; accepted only when busy=0.
- value  input  IN_WIDTH  unsigned binary word to display.
- mode  input  1  0 = decimal, 1 = hexadecimal; sampled with start.
- blank_lz  input  1  1 = blank leading zero digits; sampled with start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when hex_out is updated.
- overflow  output  1  last accepted value did not fit in DIGITS digits.
- hex_out  output  7*DIGITS  segments; digit i at [7i+6:7i], digit 0 = least significant; bit order g,f,e,d,c,b,a (bit 6..0); 0 = segment lit.

Behaviour:

Reset (asynchronous, any state, including mid-conversion):
- Aborts the conversion; state goes to IDLE.
- hex_out is all ones (all blank); busy=0, done=0, overflow=0.

States: IDLE, SHIFT, ENCODE.
- IDLE: on an edge with start=1, latch value, mode and blank_lz; clear the BCD register; load the shift counter with IN_WIDTH; set busy=1. Next state is SHIFT if mode=0, ENCODE if mode=1.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Decrement the counter; go to ENCODE after exactly IN_WIDTH SHIFT cycles.
- ENCODE: one cycle. On its closing edge, write all hex_out digits, write overflow, pulse done=1 for one cycle, clear busy, return to IDLE.

Latency from the edge that accepts start to the edge that writes hex_out:
- Hex mode: 1 cycle.
- Decimal mode: IN_WIDTH+1 cycles.

Handshake and output holding:
- start while busy=1 is ignored; no queuing.
- start on the same edge as the ENCODE completion is also ignored. A new start is accepted only in IDLE.
- hex_out and overflow hold their values between conversions. All digits update atomically; no partial digit values are ever visible.

Overflow:
- Decimal: set when the latched value > 10^DIGITS − 1, computed at latch time as a constant compare.
- Hex: set when any latched bit at index ≥ 4*DIGITS is 1.
- When overflow=1, every digit shows dash 0111111 regardless of blank_lz.
- When 4*DIGITS > IN_WIDTH, the missing upper nibbles are treated as 0.
- The BCD register is 4*DIGITS bits plus enough headroom that non-overflow values convert exactly.

Glyphs:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- blank=1111111, dash=0111111.
- In decimal mode a nibble >9 cannot occur; if one does, the digit shows blank.

Leading-zero blanking (blank_lz=1, no overflow):
- Zero digits above the most significant non-zero digit show blank.
- Digit 0 is always shown, so value 0 displays "0".

Test Plan:
- Decimal conversion, DIGITS=3, IN_WIDTH=12: reset, then start with value=255, mode=0, blank_lz=0 → busy high for 13 cycles; done pulses once; hex_out = {0100100, 0010010, 0010010} ("255"); overflow=0.
- Hex conversion: start with value=12'hABC, mode=1 → one cycle later hex_out = {0001000, 0000011, 1000110} ("AbC"); done=1 for exactly one cycle.
- Leading-zero blanking: value=7, mode=0, blank_lz=1 → {1111111, 1111111, 1111000}. Then value=0 → {1111111, 1111111, 1000000}.
- Overflow: value=1000, mode=0 → all three digits 0111111, overflow=1. Next value=999 → "999", overflow=0.
- Start while busy: start with value=123, then a second start with value=456 on cycle 5 while busy → second start ignored; hex_out shows "123"; exactly one done pulse.
- Reset mid-conversion: assert reset on cycle 6 of a decimal conversion → hex_out all ones, busy=0, done never pulses; the next start converts normally.
